// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM states, access-size encodings and byte-lane mask helper
package lsu_pkg;
  typedef enum logic [2:0] {IDLE, RD, WT, WR, FIN} lsu_state_e;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;
  localparam logic [2:0] F3_XX = 3'b111;
  function automatic logic [7:0] lane_mask(input logic [2:0] f3);
    return f3[1:0] == 2'd0 ? 8'h01 : f3[1:0] == 2'd1 ? 8'h03 : f3[1:0] == 2'd2 ? 8'h0f : 8'hff;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: load lane extraction/extension and store byte-lane merge
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  f3,
  input  logic [2:0]  off,
  input  logic [63:0] rd_word,
  input  logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic [63:0] store_data
);
  logic [63:0] sh, ws, bm;
  logic [7:0]  mask;
  assign sh   = rd_word >> {off, 3'b000};
  assign ws   = wdata << {off, 3'b000};
  assign mask = lane_mask(f3) << off;
  for (genvar i = 0; i < 8; i++) begin : g_lane
    assign bm[8*i +: 8] = {8{mask[i]}};
  end
  assign store_data = (ws & bm) | (rd_word & ~bm);
  assign load_data  = f3 == F3_B  ? {{56{sh[7]}}, sh[7:0]} :
                      f3 == F3_H  ? {{48{sh[15]}}, sh[15:0]} :
                      f3 == F3_W  ? {{32{sh[31]}}, sh[31:0]} :
                      f3 == F3_BU ? {56'd0, sh[7:0]} :
                      f3 == F3_HU ? {48'd0, sh[15:0]} :
                      f3 == F3_WU ? {32'd0, sh[31:0]} : sh;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store FSM with alignment checks and read-modify-write for partial stores
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        IS_STORE,
  input  logic [2:0]  FUNCT3,
  input  logic [63:0] ADDR,
  input  logic [63:0] WDATA,
  output logic [63:0] MEM_ADDR,
  output logic        MEM_WR,
  output logic [63:0] MEM_DIN,
  input  logic [63:0] MEM_DOUT,
  output logic [63:0] RDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        MISALIGNED
);
  lsu_state_e  state_q, state_d;
  logic [63:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, mem_din_q, mem_din_d;
  logic [2:0]  f3_q, f3_d;
  logic        st_q, st_d, busy_q, busy_d, done_q, done_d, mis_q, mis_d, mem_wr_q, mem_wr_d;
  logic        err;
  logic [63:0] load_data, store_data;
  lsu_align u_align (
    .f3(f3_q), .off(addr_q[2:0]), .rd_word(MEM_DOUT), .wdata(wdata_q),
    .load_data(load_data), .store_data(store_data)
  );
  // unsupported encodings share the misaligned error path
  assign err = FUNCT3 == F3_XX || (IS_STORE && FUNCT3[2]) ||
               (FUNCT3[1:0] == 2'd1 ? ADDR[0] : FUNCT3[1:0] == 2'd2 ? |ADDR[1:0] :
                FUNCT3[1:0] == 2'd3 ? |ADDR[2:0] : 1'b0);
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    f3_d      = f3_q;
    st_d      = st_q;
    rdata_d   = rdata_q;
    mem_din_d = mem_din_q;
    done_d    = 1'b0;
    mis_d     = 1'b0;
    mem_wr_d  = 1'b0;
    case (state_q)
      IDLE: if (START) begin
        addr_d  = ADDR;
        wdata_d = WDATA;
        f3_d    = FUNCT3;
        st_d    = IS_STORE;
        if (err) begin
          state_d = FIN;
          done_d  = 1'b1;
          mis_d   = 1'b1;
        end else if (IS_STORE && FUNCT3 == F3_D) begin
          state_d   = WR;
          mem_wr_d  = 1'b1;
          mem_din_d = WDATA;
        end else state_d = RD;
      end
      RD: state_d = WT;
      WT: if (st_q) begin
        state_d   = WR;
        mem_wr_d  = 1'b1;
        mem_din_d = store_data;
      end else begin
        state_d = FIN;
        done_d  = 1'b1;
        rdata_d = load_data;
      end
      WR: begin
        state_d = FIN;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      st_q      <= 1'b0;
      rdata_q   <= '0;
      mem_din_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mis_q     <= 1'b0;
      mem_wr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      f3_q      <= f3_d;
      st_q      <= st_d;
      rdata_q   <= rdata_d;
      mem_din_q <= mem_din_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mis_q     <= mis_d;
      mem_wr_q  <= mem_wr_d;
    end
  end
  assign MEM_ADDR   = state_q == IDLE ? {ADDR[63:3], 3'b000} : {addr_q[63:3], 3'b000};
  assign MEM_WR     = mem_wr_q;
  assign MEM_DIN    = mem_din_q;
  assign RDATA      = rdata_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign MISALIGNED = mis_q;
endmodule
